uart_rx_framed: RTL and testbench

//  Parametrised UART receiver: 5-9 data bits, none/even/odd parity, 1 or 2 stop bits.
//  3-sample majority vote per bit, false-start rejection, parity/framing/break/overrun

---
 rtl/uart_rx_framed_pkg.sv | 29 ++
 rtl/uart_rx_fifo.sv | 68 ++++++
 rtl/uart_rx_framed.sv | 204 ++++++++++++++++++++
 tb/tb_uart_rx_framed.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_framed_pkg.sv
// rtl/uart_rx_framed_pkg.sv - shared types and helpers for the framed UART receiver
//   uart_parity_e   : line parity mode (none / even / odd)
//   uart_rx_state_e : one-hot receiver FSM states
//   maj3()          : 2-of-3 majority used for bit-centre voting
package uart_rx_framed_pkg;

  typedef logic [7:0]  u8;
  typedef logic [15:0] u16;
  typedef logic [31:0] u32;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } uart_parity_e;

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    START  = 5'b00010,
    DATA   = 5'b00100,
    PARITY = 5'b01000,
    STOP   = 5'b10000
  } uart_rx_state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - single-clock FIFO with one-cycle registered read
//   clk, srst      : clock, synchronous active-high reset
//   wr_en, din     : push (accepted when not full, or when a pop happens in the same clk)
//   rd_en          : pop request, ignored while empty
//   dout, valid    : popped word and its qualifier, one clk after an accepted rd_en
//   empty, full    : occupancy flags
//   data_count     : entries held
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   data_count
);

  localparam int AW = $clog2(DEPTH);

  if ((DEPTH < 2) || ((1 << AW) != DEPTH)) begin : g_depth_check
    $error("uart_rx_fifo: DEPTH must be a power of 2 and >= 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_wr;
  logic             do_rd;

  assign empty = (data_count == '0);
  assign full  = (data_count == (AW+1)'(DEPTH));
  assign do_rd = rd_en && !empty;
  // A simultaneous pop frees the slot, so a push into a full FIFO still lands.
  assign do_wr = wr_en && (!full || do_rd);

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wptr       <= '0;
      rptr       <= '0;
      data_count <= '0;
      dout       <= '0;
      valid      <= 1'b0;
    end else begin
      valid <= do_rd;
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) begin
        dout <= mem[rptr];
        rptr <= rptr + 1'b1;
      end
      case ({do_wr, do_rd})
        2'b10:   data_count <= data_count + 1'b1;
        2'b01:   data_count <= data_count - 1'b1;
        default: data_count <= data_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_rx_framed.sv
// rtl/uart_rx_framed.sv - parametrised UART receiver with status-tagged FIFO
//   clk, srst          : clock, synchronous active-high reset
//   rx                 : asynchronous serial line, idle high
//   rd_en              : FIFO pop request
//   dout, dout_perr,
//   dout_ferr, valid   : popped frame, its parity/framing flags, qualifier
//   empty, full,
//   data_count         : FIFO occupancy
//   overrun            : sticky, a frame was dropped on a full FIFO
//   break_det          : one-clk pulse when a break frame is stored
//   clr_status         : clears overrun
module uart_rx_framed #(
  parameter int CLK_IN    = 100_000_000,
  parameter int BAUD      = 115_200,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DEPTH     = 16
) (
  input  logic                   clk,
  input  logic                   srst,
  input  logic                   rx,
  input  logic                   rd_en,
  output logic [DATA_BITS-1:0]   dout,
  output logic                   dout_perr,
  output logic                   dout_ferr,
  output logic                   valid,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] data_count,
  output logic                   overrun,
  output logic                   break_det,
  input  logic                   clr_status
);

  import uart_rx_framed_pkg::*;

  localparam int CPB = CLK_IN / BAUD;
  localparam int TW  = $clog2(CPB);
  localparam int CTR = CPB / 2;
  localparam logic [TW-1:0] T_LAST  = TW'(CPB - 1);
  localparam logic [TW-1:0] T_LO    = TW'(CTR - 1);
  localparam logic [TW-1:0] T_MID   = TW'(CTR);
  localparam logic [TW-1:0] T_HI    = TW'(CTR + 1);
  localparam logic [3:0]    DB_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]    SB_LAST = 4'(STOP_BITS - 1);
  localparam logic          ODD_PAR = (PARITY == int'(PAR_ODD));

  if (CPB < 8) begin : g_cpb_check
    $error("uart_rx_framed: CLK_IN/BAUD must be >= 8");
  end
  if ((DATA_BITS < 5) || (DATA_BITS > 9) || (STOP_BITS < 1) || (STOP_BITS > 2) ||
      (PARITY < 0) || (PARITY > 2)) begin : g_frame_check
    $error("uart_rx_framed: unsupported frame format");
  end

  uart_rx_state_e        state, state_nxt;
  logic                  rx_meta, rx_s, rx_s_d;
  logic                  start_edge;
  logic [TW-1:0]         timer;
  logic [3:0]            bit_cnt;
  logic                  s_lo, s_mid;
  logic                  decide, bit_val;
  logic [DATA_BITS-1:0]  shreg;
  logic                  perr, ferr, pbit_zero, stop_zero;
  logic                  frame_start, shift_en, par_en, stop_en, frame_done;
  logic                  wr_en, brk;
  logic [DATA_BITS+1:0]  wr_data;
  logic [DATA_BITS+1:0]  fifo_dout;

  // Preset to idle-high so reset release never looks like a start edge.
  always_ff @(posedge clk) begin
    if (srst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d  <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_s_d  <= rx_s;
    end
  end

  // Only a falling edge starts a frame, so a line stuck low after a break stays quiet.
  assign start_edge = rx_s_d & ~rx_s;
  assign decide     = (timer == T_HI);
  assign bit_val    = maj3(s_lo, s_mid, rx_s);

  always_ff @(posedge clk) begin
    if (srst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start_edge) state_nxt = START;
      START: if (decide) state_nxt = bit_val ? IDLE : DATA;
      DATA:  if (decide && (bit_cnt == DB_LAST))
               state_nxt = (PARITY != 0) ? uart_rx_framed_pkg::PARITY : STOP;
      uart_rx_framed_pkg::PARITY: if (decide) state_nxt = STOP;
      STOP:  if (decide && (bit_cnt == SB_LAST)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    frame_start = 1'b0;
    shift_en    = 1'b0;
    par_en      = 1'b0;
    stop_en     = 1'b0;
    frame_done  = 1'b0;
    case (state)
      IDLE:  frame_start = start_edge;
      DATA:  shift_en    = decide;
      uart_rx_framed_pkg::PARITY: par_en = decide;
      STOP: begin
        stop_en    = decide;
        frame_done = decide && (bit_cnt == SB_LAST);
      end
      default: ;
    endcase
  end

  // The bit timer free-runs from the start edge, so every decision lands one
  // full bit period after the previous one regardless of state changes.
  always_ff @(posedge clk) begin
    if (srst) begin
      timer     <= '0;
      bit_cnt   <= '0;
      s_lo      <= 1'b1;
      s_mid     <= 1'b1;
      shreg     <= '0;
      perr      <= 1'b0;
      ferr      <= 1'b0;
      pbit_zero <= 1'b1;
      stop_zero <= 1'b1;
      wr_en     <= 1'b0;
      wr_data   <= '0;
      brk       <= 1'b0;
    end else begin
      wr_en <= frame_done;
      brk   <= frame_done && (shreg == '0) && pbit_zero && stop_zero && !bit_val;
      if (frame_done) wr_data <= {ferr | ~bit_val, perr, shreg};

      if (state == IDLE)       timer <= '0;
      else if (timer == T_LAST) timer <= '0;
      else                      timer <= timer + 1'b1;

      if (timer == T_LO)  s_lo  <= rx_s;
      if (timer == T_MID) s_mid <= rx_s;

      if (frame_start) begin
        bit_cnt   <= '0;
        perr      <= 1'b0;
        ferr      <= 1'b0;
        pbit_zero <= 1'b1;
        stop_zero <= 1'b1;
      end else if (decide) begin
        bit_cnt <= (state_nxt != state) ? 4'd0 : bit_cnt + 4'd1;
      end

      if (shift_en) shreg <= {bit_val, shreg[DATA_BITS-1:1]};
      if (par_en) begin
        perr      <= ((^shreg) ^ bit_val) != ODD_PAR;
        pbit_zero <= ~bit_val;
      end
      if (stop_en) begin
        if (!bit_val) ferr      <= 1'b1;
        else          stop_zero <= 1'b0;
      end
    end
  end

  // A new overrun wins over a same-cycle clear.
  always_ff @(posedge clk) begin
    if (srst)                             overrun <= 1'b0;
    else if (wr_en && full && !rd_en)     overrun <= 1'b1;
    else if (clr_status)                  overrun <= 1'b0;
  end

  assign break_det = brk;

  uart_rx_fifo #(
    .WIDTH (DATA_BITS + 2),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .srst       (srst),
    .wr_en      (wr_en),
    .din        (wr_data),
    .rd_en      (rd_en),
    .dout       (fifo_dout),
    .valid      (valid),
    .empty      (empty),
    .full       (full),
    .data_count (data_count)
  );

  assign dout      = fifo_dout[DATA_BITS-1:0];
  assign dout_perr = fifo_dout[DATA_BITS];
  assign dout_ferr = fifo_dout[DATA_BITS+1];

endmodule

// File: tb/tb_uart_rx_framed.sv
// tb/tb_uart_rx_framed.sv - scoreboard bench for uart_rx_framed
module tb_uart_rx_framed;

  localparam int BIT = 100;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       srst;
  logic [3:0] rx_v, rd_v, clr_v;
  wire  [3:0] valid_v, empty_v, full_v, ovr_v, brk_v, perr_v, ferr_v;
  wire  [7:0] dout0, dout1, dout2;
  wire  [8:0] dout3;
  wire  [4:0] cnt0, cnt1, cnt3;
  wire  [2:0] cnt2;

  uart_rx_framed #(.CLK_IN(100_000_000), .BAUD(1_000_000), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .DEPTH(16)) u0 (
    .clk(clk), .srst(srst), .rx(rx_v[0]), .rd_en(rd_v[0]), .dout(dout0),
    .dout_perr(perr_v[0]), .dout_ferr(ferr_v[0]), .valid(valid_v[0]), .empty(empty_v[0]),
    .full(full_v[0]), .data_count(cnt0), .overrun(ovr_v[0]), .break_det(brk_v[0]),
    .clr_status(clr_v[0]));

  uart_rx_framed #(.CLK_IN(100_000_000), .BAUD(1_000_000), .DATA_BITS(8), .PARITY(1),
                   .STOP_BITS(1), .DEPTH(16)) u1 (
    .clk(clk), .srst(srst), .rx(rx_v[1]), .rd_en(rd_v[1]), .dout(dout1),
    .dout_perr(perr_v[1]), .dout_ferr(ferr_v[1]), .valid(valid_v[1]), .empty(empty_v[1]),
    .full(full_v[1]), .data_count(cnt1), .overrun(ovr_v[1]), .break_det(brk_v[1]),
    .clr_status(clr_v[1]));

  uart_rx_framed #(.CLK_IN(100_000_000), .BAUD(1_000_000), .DATA_BITS(8), .PARITY(0),
                   .STOP_BITS(1), .DEPTH(4)) u2 (
    .clk(clk), .srst(srst), .rx(rx_v[2]), .rd_en(rd_v[2]), .dout(dout2),
    .dout_perr(perr_v[2]), .dout_ferr(ferr_v[2]), .valid(valid_v[2]), .empty(empty_v[2]),
    .full(full_v[2]), .data_count(cnt2), .overrun(ovr_v[2]), .break_det(brk_v[2]),
    .clr_status(clr_v[2]));

  uart_rx_framed #(.CLK_IN(100_000_000), .BAUD(1_000_000), .DATA_BITS(9), .PARITY(0),
                   .STOP_BITS(2), .DEPTH(16)) u3 (
    .clk(clk), .srst(srst), .rx(rx_v[3]), .rd_en(rd_v[3]), .dout(dout3),
    .dout_perr(perr_v[3]), .dout_ferr(ferr_v[3]), .valid(valid_v[3]), .empty(empty_v[3]),
    .full(full_v[3]), .data_count(cnt3), .overrun(ovr_v[3]), .break_det(brk_v[3]),
    .clr_status(clr_v[3]));

  int         cur;
  logic [8:0] o_dout;
  logic [4:0] o_cnt;
  logic       o_valid, o_empty, o_full, o_ovr, o_brk, o_perr, o_ferr;

  always_comb begin
    case (cur)
      1:       begin o_dout = {1'b0, dout1}; o_cnt = cnt1;         end
      2:       begin o_dout = {1'b0, dout2}; o_cnt = {2'b00, cnt2}; end
      3:       begin o_dout = dout3;         o_cnt = cnt3;         end
      default: begin o_dout = {1'b0, dout0}; o_cnt = cnt0;         end
    endcase
  end
  assign o_valid = valid_v[cur[1:0]];
  assign o_empty = empty_v[cur[1:0]];
  assign o_full  = full_v[cur[1:0]];
  assign o_ovr   = ovr_v[cur[1:0]];
  assign o_brk   = brk_v[cur[1:0]];
  assign o_perr  = perr_v[cur[1:0]];
  assign o_ferr  = ferr_v[cur[1:0]];

  int          errors = 0;
  int          checks = 0;
  logic [10:0] exp_q[$];

  function automatic logic [10:0] ent(input logic f, input logic p, input logic [8:0] d);
    return {f, p, d};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int d, input logic [8:0] data, input int nbits,
                            input bit use_par, input logic pbit, input logic stop_val,
                            input int nstop);
    rx_v[d] = 1'b0;
    tick(BIT);
    for (int i = 0; i < nbits; i++) begin
      rx_v[d] = data[i];
      tick(BIT);
    end
    if (use_par) begin
      rx_v[d] = pbit;
      tick(BIT);
    end
    for (int i = 0; i < nstop; i++) begin
      rx_v[d] = stop_val;
      tick(BIT);
    end
  endtask

  task automatic read_check(input int d, input string name);
    logic [10:0] e;
    logic [10:0] got;
    cur = d;
    tick(1);
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", name);
      return;
    end
    e = exp_q.pop_front();
    rd_v[d] = 1'b1;
    @(negedge clk);
    checks++;
    if (o_valid !== 1'b0) begin errors++; $display("FAIL %s_valid_early: got %b want 0", name, o_valid); end
    @(posedge clk); #1;
    rd_v[d] = 1'b0;
    checks++;
    if (o_valid !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b want 1", name, o_valid); end
    got = {o_ferr, o_perr, o_dout};
    checks++;
    if (got !== e) begin errors++; $display("FAIL %s_data: got ferr/perr/data %h want %h", name, got, e); end
  endtask

  task automatic check_cnt(input int d, input logic [4:0] want, input string name);
    cur = d;
    @(negedge clk);
    checks++;
    if (o_cnt !== want) begin errors++; $display("FAIL %s_count: got %0d want %0d", name, o_cnt, want); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    srst = 1'b1; rx_v = '1; rd_v = '0; clr_v = '0; cur = 0;
    tick(4);
    @(negedge clk);
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b want 1", o_empty); end
    checks++; if (o_full !== 1'b0)  begin errors++; $display("FAIL rst_full: got %b want 0", o_full); end
    checks++; if (o_cnt !== 5'd0)   begin errors++; $display("FAIL rst_count: got %0d want 0", o_cnt); end
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", o_valid); end
    checks++; if (o_ovr !== 1'b0)   begin errors++; $display("FAIL rst_overrun: got %b want 0", o_ovr); end
    checks++; if (o_brk !== 1'b0)   begin errors++; $display("FAIL rst_break: got %b want 0", o_brk); end
    checks++; if ({o_ferr, o_perr, o_dout} !== 11'd0) begin errors++; $display("FAIL rst_dout: got %h want 0", {o_ferr, o_perr, o_dout}); end
    @(posedge clk); #1;
    srst = 1'b0;
    tick(5);
  endtask

  task automatic test_basic();
    exp_q.push_back(ent(1'b0, 1'b0, 9'h0A5));
    send_frame(0, 9'h0A5, 8, 1'b0, 1'b0, 1'b1, 1);
    check_cnt(0, 5'd1, "basic");
    read_check(0, "basic");
    check_cnt(0, 5'd0, "basic_after");
  endtask

  task automatic test_parity();
    exp_q.push_back(ent(1'b0, 1'b0, 9'h007));
    send_frame(1, 9'h007, 8, 1'b1, 1'b1, 1'b1, 1);
    exp_q.push_back(ent(1'b0, 1'b1, 9'h007));
    send_frame(1, 9'h007, 8, 1'b1, 1'b0, 1'b1, 1);
    check_cnt(1, 5'd2, "parity");
    read_check(1, "parity_good");
    read_check(1, "parity_bad");
  endtask

  task automatic test_glitch();
    rx_v[0] = 1'b0;
    tick(30);
    rx_v[0] = 1'b1;
    tick(3 * BIT);
    check_cnt(0, 5'd0, "glitch");
    exp_q.push_back(ent(1'b0, 1'b0, 9'h03C));
    send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1'b1, 1);
    read_check(0, "glitch_next");
  endtask

  task automatic test_framing();
    exp_q.push_back(ent(1'b1, 1'b0, 9'h03C));
    send_frame(0, 9'h03C, 8, 1'b0, 1'b0, 1'b0, 1);
    rx_v[0] = 1'b1;
    tick(BIT);
    read_check(0, "framing");
  endtask

  task automatic test_break();
    int nbrk;
    nbrk = 0;
    cur = 0;
    exp_q.push_back(ent(1'b1, 1'b0, 9'h000));
    rx_v[0] = 1'b0;
    repeat (20 * BIT) begin
      @(negedge clk);
      if (o_brk) nbrk++;
    end
    checks++;
    if (nbrk != 1) begin errors++; $display("FAIL break_pulses: got %0d want 1", nbrk); end
    @(posedge clk); #1;
    check_cnt(0, 5'd1, "break_held");
    rx_v[0] = 1'b1;
    tick(3 * BIT);
    check_cnt(0, 5'd1, "break_released");
    read_check(0, "break");
  endtask

  task automatic test_back_to_back();
    exp_q.push_back(ent(1'b0, 1'b0, 9'h081));
    send_frame(0, 9'h081, 8, 1'b0, 1'b0, 1'b1, 1);
    exp_q.push_back(ent(1'b0, 1'b0, 9'h07E));
    send_frame(0, 9'h07E, 8, 1'b0, 1'b0, 1'b1, 1);
    check_cnt(0, 5'd2, "b2b");
    read_check(0, "b2b_first");
    read_check(0, "b2b_second");
  endtask

  task automatic test_overrun();
    logic [8:0] v;
    for (int i = 1; i <= 5; i++) begin
      v = 9'(i);
      if (i <= 4) exp_q.push_back(ent(1'b0, 1'b0, v));
      send_frame(2, v, 8, 1'b0, 1'b0, 1'b1, 1);
    end
    cur = 2;
    @(negedge clk);
    checks++; if (o_full !== 1'b1) begin errors++; $display("FAIL ovr_full: got %b want 1", o_full); end
    checks++; if (o_ovr !== 1'b1)  begin errors++; $display("FAIL ovr_set: got %b want 1", o_ovr); end
    checks++; if (o_cnt !== 5'd4)  begin errors++; $display("FAIL ovr_count: got %0d want 4", o_cnt); end
    @(posedge clk); #1;
    clr_v[2] = 1'b1;
    tick(1);
    clr_v[2] = 1'b0;
    @(negedge clk);
    checks++; if (o_ovr !== 1'b0) begin errors++; $display("FAIL ovr_clear: got %b want 0", o_ovr); end
    @(posedge clk); #1;
    for (int i = 1; i <= 4; i++) read_check(2, "ovr_read");
    check_cnt(2, 5'd0, "ovr_drained");
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    d = 8'h5A;
    send_frame(0, 9'h011, 8, 1'b0, 1'b0, 1'b1, 1);
    check_cnt(0, 5'd1, "rstmid_pre");
    rx_v[0] = 1'b0;
    tick(BIT);
    for (int i = 0; i < 3; i++) begin
      rx_v[0] = d[i];
      tick(BIT);
    end
    rx_v[0] = d[3];
    tick(BIT / 2);
    srst = 1'b1;
    rx_v[0] = 1'b1;
    tick(2);
    srst = 1'b0;
    tick(BIT);
    cur = 0;
    @(negedge clk);
    checks++; if (o_empty !== 1'b1) begin errors++; $display("FAIL rstmid_empty: got %b want 1", o_empty); end
    checks++; if (o_cnt !== 5'd0)   begin errors++; $display("FAIL rstmid_count: got %0d want 0", o_cnt); end
    @(posedge clk); #1;
    exp_q.push_back(ent(1'b0, 1'b0, 9'h05A));
    send_frame(0, 9'h05A, 8, 1'b0, 1'b0, 1'b1, 1);
    read_check(0, "rstmid_next");
  endtask

  task automatic test_wide();
    exp_q.push_back(ent(1'b0, 1'b0, 9'h1FF));
    send_frame(3, 9'h1FF, 9, 1'b0, 1'b0, 1'b1, 2);
    exp_q.push_back(ent(1'b0, 1'b0, 9'h12A));
    send_frame(3, 9'h12A, 9, 1'b0, 1'b0, 1'b1, 2);
    read_check(3, "wide_1ff");
    read_check(3, "wide_12a");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_glitch();
    test_framing();
    test_break();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    test_wide();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_left: got %0d want 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
